// File: rtl/rc5_job_scheduler_if.sv
// Connection bundle between rc5_job_scheduler (master) and the RC5 core (slave).
// Carries the key-RAM write port, the start levels, the operands, the results and the done flags.
interface rc5_job_scheduler_if #(
   parameter int W        = 32,
   parameter int B_LENGTH = 4
);
   logic [7:0]          oKey_sub_i;
   logic [B_LENGTH-1:0] oKey_address;
   logic                oWen;
   logic                oStartCipher;
   logic                oStartDecipher;
   logic [W-1:0]        oA;
   logic [W-1:0]        oB;
   logic [W-1:0]        iA_cipher;
   logic [W-1:0]        iB_cipher;
   logic [W-1:0]        iA_decipher;
   logic [W-1:0]        iB_decipher;
   logic                iDoneCipher;
   logic                iDoneDecipher;

   modport master (
      output oKey_sub_i, oKey_address, oWen, oStartCipher, oStartDecipher, oA, oB,
      input  iA_cipher, iB_cipher, iA_decipher, iB_decipher, iDoneCipher, iDoneDecipher
   );

   modport slave (
      input  oKey_sub_i, oKey_address, oWen, oStartCipher, oStartDecipher, oA, oB,
      output iA_cipher, iB_cipher, iA_decipher, iB_decipher, iDoneCipher, iDoneDecipher
   );
endinterface

// File: rtl/rc5_job_scheduler.sv
// Key loader and two-requester round-robin job scheduler in front of the RC5 core.
// Optional RUN watchdog enabled by defining RC5_SCHED_TIMEOUT_EN (adds port oTimeout).
module rc5_job_scheduler #(
   parameter int W       = 32,
   parameter int B       = 16,
   parameter int TIMEOUT = 4095
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         iKeyValid,
   input  logic [7:0]   iKeyByte,
   output logic         oKeyReady,
   input  logic         iKeyReload,
   output logic         oKeyLoaded,
   input  logic         iReq0,
   input  logic         iReq1,
   input  logic         iOp0,
   input  logic         iOp1,
   input  logic [W-1:0] iA0,
   input  logic [W-1:0] iB0,
   input  logic [W-1:0] iA1,
   input  logic [W-1:0] iB1,
   output logic         oGnt0,
   output logic         oGnt1,
   output logic         oRespValid,
   output logic         oRespId,
   output logic [W-1:0] oRespA,
   output logic [W-1:0] oRespB,
   output logic         oBusy,
`ifdef RC5_SCHED_TIMEOUT_EN
   output logic         oTimeout,
`endif
   rc5_job_scheduler_if.master core
);
   localparam int B_LENGTH = $clog2(B);

   typedef enum logic [2:0] {KEY_LOAD, IDLE, RUN, RESP, GAP} state_t;

   state_t              state_q, state_d;
   logic [B_LENGTH-1:0] key_cnt_q, key_cnt_d;
   logic                key_ready_q, key_ready_d;
   logic                key_loaded_q, key_loaded_d;
   logic                wen_q, wen_d;
   logic [B_LENGTH-1:0] key_addr_q, key_addr_d;
   logic [7:0]          key_sub_q, key_sub_d;
   logic                gnt0_q, gnt0_d;
   logic                gnt1_q, gnt1_d;
   logic                last_q, last_d;
   logic                op_q, op_d;
   logic                id_q, id_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic                start_cipher_q, start_cipher_d;
   logic                start_decipher_q, start_decipher_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_id_q, resp_id_d;
   logic [W-1:0]        resp_a_q, resp_a_d;
   logic [W-1:0]        resp_b_q, resp_b_d;
   logic                busy_q, busy_d;
   logic                reload_pend_q, reload_pend_d;
   logic                pick;
   logic                done_hit;
`ifdef RC5_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                timeout_q, timeout_d;
`endif

   always_comb begin
      state_d          = state_q;
      key_cnt_d        = key_cnt_q;
      key_ready_d      = key_ready_q;
      key_loaded_d     = key_loaded_q;
      wen_d            = 1'b0;
      key_addr_d       = key_addr_q;
      key_sub_d        = key_sub_q;
      gnt0_d           = 1'b0;
      gnt1_d           = 1'b0;
      last_d           = last_q;
      op_d             = op_q;
      id_d             = id_q;
      a_d              = a_q;
      b_d              = b_q;
      start_cipher_d   = start_cipher_q;
      start_decipher_d = start_decipher_q;
      resp_valid_d     = 1'b0;
      resp_id_d        = resp_id_q;
      resp_a_d         = resp_a_q;
      resp_b_d         = resp_b_q;
      reload_pend_d    = reload_pend_q;
`ifdef RC5_SCHED_TIMEOUT_EN
      tmo_cnt_d        = tmo_cnt_q;
      timeout_d        = 1'b0;
`endif
      // Tie goes to whoever was not served last; a lone request wins outright.
      pick     = (iReq0 && iReq1) ? ~last_q : iReq1;
      done_hit = op_q ? core.iDoneDecipher : core.iDoneCipher;

      if (iKeyReload && (state_q == RUN || state_q == RESP || state_q == GAP))
         reload_pend_d = 1'b1;

      case (state_q)
         KEY_LOAD: begin
            if (iKeyReload) begin
               key_cnt_d = '0;
            end else if (iKeyValid && key_ready_q) begin
               wen_d      = 1'b1;
               key_addr_d = key_cnt_q;
               key_sub_d  = iKeyByte;
               key_cnt_d  = key_cnt_q + B_LENGTH'(1);
               if (key_cnt_q == B_LENGTH'(B - 1)) begin
                  key_ready_d  = 1'b0;
                  key_loaded_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         // GAP shares the IDLE decision so a waiting request is granted right after it.
         IDLE, GAP: begin
            if (iKeyReload || reload_pend_q) begin
               state_d       = KEY_LOAD;
               key_cnt_d     = '0;
               key_ready_d   = 1'b1;
               key_loaded_d  = 1'b0;
               reload_pend_d = 1'b0;
            end else if (key_loaded_q && (iReq0 || iReq1)) begin
               gnt0_d           = ~pick;
               gnt1_d           = pick;
               last_d           = pick;
               id_d             = pick;
               op_d             = pick ? iOp1 : iOp0;
               a_d              = pick ? iA1 : iA0;
               b_d              = pick ? iB1 : iB0;
               start_cipher_d   = ~(pick ? iOp1 : iOp0);
               start_decipher_d = pick ? iOp1 : iOp0;
               state_d          = RUN;
`ifdef RC5_SCHED_TIMEOUT_EN
               tmo_cnt_d        = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (done_hit) begin
               resp_valid_d     = 1'b1;
               resp_id_d        = id_q;
               resp_a_d         = op_q ? core.iA_decipher : core.iA_cipher;
               resp_b_d         = op_q ? core.iB_decipher : core.iB_cipher;
               start_cipher_d   = 1'b0;
               start_decipher_d = 1'b0;
               state_d          = RESP;
`ifdef RC5_SCHED_TIMEOUT_EN
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               resp_valid_d     = 1'b1;
               resp_id_d        = id_q;
               resp_a_d         = '0;
               resp_b_d         = '0;
               timeout_d        = 1'b1;
               start_cipher_d   = 1'b0;
               start_decipher_d = 1'b0;
               state_d          = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
            end
         end
         RESP:    state_d = GAP;
         default: state_d = KEY_LOAD;
      endcase

      busy_d = (state_d == RUN) || (state_d == RESP) || (state_d == GAP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= KEY_LOAD;
         key_cnt_q        <= '0;
         key_ready_q      <= 1'b1;
         key_loaded_q     <= 1'b0;
         wen_q            <= 1'b0;
         key_addr_q       <= '0;
         key_sub_q        <= '0;
         gnt0_q           <= 1'b0;
         gnt1_q           <= 1'b0;
         last_q           <= 1'b1;
         op_q             <= 1'b0;
         id_q             <= 1'b0;
         a_q              <= '0;
         b_q              <= '0;
         start_cipher_q   <= 1'b0;
         start_decipher_q <= 1'b0;
         resp_valid_q     <= 1'b0;
         resp_id_q        <= 1'b0;
         resp_a_q         <= '0;
         resp_b_q         <= '0;
         busy_q           <= 1'b0;
         reload_pend_q    <= 1'b0;
`ifdef RC5_SCHED_TIMEOUT_EN
         tmo_cnt_q        <= '0;
         timeout_q        <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         key_cnt_q        <= key_cnt_d;
         key_ready_q      <= key_ready_d;
         key_loaded_q     <= key_loaded_d;
         wen_q            <= wen_d;
         key_addr_q       <= key_addr_d;
         key_sub_q        <= key_sub_d;
         gnt0_q           <= gnt0_d;
         gnt1_q           <= gnt1_d;
         last_q           <= last_d;
         op_q             <= op_d;
         id_q             <= id_d;
         a_q              <= a_d;
         b_q              <= b_d;
         start_cipher_q   <= start_cipher_d;
         start_decipher_q <= start_decipher_d;
         resp_valid_q     <= resp_valid_d;
         resp_id_q        <= resp_id_d;
         resp_a_q         <= resp_a_d;
         resp_b_q         <= resp_b_d;
         busy_q           <= busy_d;
         reload_pend_q    <= reload_pend_d;
`ifdef RC5_SCHED_TIMEOUT_EN
         tmo_cnt_q        <= tmo_cnt_d;
         timeout_q        <= timeout_d;
`endif
      end
   end

   assign oKeyReady           = key_ready_q;
   assign oKeyLoaded          = key_loaded_q;
   assign oGnt0               = gnt0_q;
   assign oGnt1               = gnt1_q;
   assign oRespValid          = resp_valid_q;
   assign oRespId             = resp_id_q;
   assign oRespA              = resp_a_q;
   assign oRespB              = resp_b_q;
   assign oBusy               = busy_q;
`ifdef RC5_SCHED_TIMEOUT_EN
   assign oTimeout            = timeout_q;
`endif
   assign core.oKey_sub_i     = key_sub_q;
   assign core.oKey_address   = key_addr_q;
   assign core.oWen           = wen_q;
   assign core.oStartCipher   = start_cipher_q;
   assign core.oStartDecipher = start_decipher_q;
   assign core.oA             = a_q;
   assign core.oB             = b_q;
endmodule

// File: tb/tb_rc5_job_scheduler.sv
// Directed bench for rc5_job_scheduler; the bench itself stands in for the RC5 core.
// Expected values are hand-written constants; inputs change and outputs are sampled on the falling edge.
module tb_rc5_job_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic        iKeyValid, iKeyReload;
   logic [7:0]  iKeyByte;
   logic        oKeyReady, oKeyLoaded;
   logic        iReq0, iReq1, iOp0, iOp1;
   logic [31:0] iA0, iB0, iA1, iB1;
   logic        oGnt0, oGnt1, oRespValid, oRespId, oBusy;
   logic [31:0] oRespA, oRespB;
`ifdef RC5_SCHED_TIMEOUT_EN
   logic        oTimeout;
`endif
   int checks   = 0;
   int failures = 0;

   rc5_job_scheduler_if #(.W(32), .B_LENGTH(4)) core_if ();

   rc5_job_scheduler #(.W(32), .B(16), .TIMEOUT(4095)) dut (
      .clk(clk), .rst(rst),
      .iKeyValid(iKeyValid), .iKeyByte(iKeyByte), .oKeyReady(oKeyReady),
      .iKeyReload(iKeyReload), .oKeyLoaded(oKeyLoaded),
      .iReq0(iReq0), .iReq1(iReq1), .iOp0(iOp0), .iOp1(iOp1),
      .iA0(iA0), .iB0(iB0), .iA1(iA1), .iB1(iB1),
      .oGnt0(oGnt0), .oGnt1(oGnt1),
      .oRespValid(oRespValid), .oRespId(oRespId), .oRespA(oRespA), .oRespB(oRespB),
      .oBusy(oBusy),
`ifdef RC5_SCHED_TIMEOUT_EN
      .oTimeout(oTimeout),
`endif
      .core(core_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Streams 16 bytes with valid held; each write must land the cycle after acceptance.
   task automatic load_key(input logic [7:0] base, input logic [7:0] step);
      int gnt_seen = 0;
      iKeyValid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         iKeyByte = base + step * 8'(i);
         @(negedge clk);
         if (oGnt0 || oGnt1) gnt_seen++;
         check_eq($sformatf("key_wen[%0d]", i), oWen_w(), 1);
         check_eq($sformatf("key_addr[%0d]", i), core_if.oKey_address, i);
         check_eq($sformatf("key_byte[%0d]", i), core_if.oKey_sub_i, base + step * 8'(i));
         if (i == 14) check_eq("key_loaded_early", oKeyLoaded, 0);
      end
      iKeyValid = 1'b0;
      check_eq("key_loaded", oKeyLoaded, 1);
      check_eq("key_ready_off", oKeyReady, 0);
      check_eq("no_gnt_in_load", gnt_seen, 0);
      $display("key load base=0x%02h step=%0d done", base, step);
   endtask

   function automatic logic oWen_w();
      return core_if.oWen;
   endfunction

   // One job: wait for grant, inject a wrong-op done, then the matching done with results.
   task automatic do_job(input int exp_id, input bit exp_op, input logic [31:0] exp_a,
                         input logic [31:0] exp_b, input int lat, input logic [31:0] ra,
                         input logic [31:0] rb, input bit drop, input bit tight, input bit reload_mid);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(oGnt0 || oGnt1) && waited < 20);
      check_eq("gnt_seen", 32'(oGnt0 | oGnt1), 1);
      if (tight) check_eq("gnt_after_gap", waited, 1);
      check_eq("gnt_id", oGnt1, exp_id);
      check_eq("gnt_excl", 32'(oGnt0 & oGnt1), 0);
      check_eq("run_a", core_if.oA, exp_a);
      check_eq("run_b", core_if.oB, exp_b);
      check_eq("start_cipher", core_if.oStartCipher, !exp_op);
      check_eq("start_decipher", core_if.oStartDecipher, exp_op);
      check_eq("busy_run", oBusy, 1);
      if (drop) begin
         if (exp_id == 1) iReq1 = 1'b0;
         else iReq0 = 1'b0;
      end
      core_if.iA_cipher   = 32'hDEAD0001;
      core_if.iB_cipher   = 32'hDEAD0002;
      core_if.iA_decipher = 32'hDEAD0003;
      core_if.iB_decipher = 32'hDEAD0004;
      if (exp_op) core_if.iDoneCipher = 1'b1;
      else core_if.iDoneDecipher = 1'b1;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         core_if.iDoneCipher   = 1'b0;
         core_if.iDoneDecipher = 1'b0;
         iKeyReload = reload_mid && (i == 0);
         check_eq("start_held", exp_op ? core_if.oStartDecipher : core_if.oStartCipher, 1);
         check_eq("starts_excl", 32'(core_if.oStartCipher & core_if.oStartDecipher), 0);
         check_eq("a_stable", core_if.oA, exp_a);
         check_eq("no_early_resp", oRespValid, 0);
      end
      iKeyReload = 1'b0;
      if (exp_op) begin
         core_if.iA_decipher = ra;
         core_if.iB_decipher = rb;
         core_if.iA_cipher   = ~ra;
         core_if.iB_cipher   = ~rb;
         core_if.iDoneDecipher = 1'b1;
      end else begin
         core_if.iA_cipher   = ra;
         core_if.iB_cipher   = rb;
         core_if.iA_decipher = ~ra;
         core_if.iB_decipher = ~rb;
         core_if.iDoneCipher = 1'b1;
      end
      @(negedge clk);
      core_if.iDoneCipher   = 1'b0;
      core_if.iDoneDecipher = 1'b0;
      check_eq("resp_valid", oRespValid, 1);
      check_eq("resp_id", oRespId, exp_id);
      check_eq("resp_a", oRespA, ra);
      check_eq("resp_b", oRespB, rb);
      check_eq("resp_starts_low", 32'(core_if.oStartCipher | core_if.oStartDecipher), 0);
      $display("job id=%0d op=%0d A=0x%08h B=0x%08h -> resp A=0x%08h B=0x%08h",
               exp_id, exp_op, exp_a, exp_b, oRespA, oRespB);
      @(negedge clk);
      check_eq("gap_resp_low", oRespValid, 0);
      check_eq("gap_starts_low", 32'(core_if.oStartCipher | core_if.oStartDecipher), 0);
      check_eq("gap_busy", oBusy, 1);
   endtask

   initial begin
      int waited;
      rst = 1'b0;
      iKeyValid = 1'b0; iKeyByte = 8'h00; iKeyReload = 1'b0;
      iReq0 = 1'b0; iReq1 = 1'b0; iOp0 = 1'b0; iOp1 = 1'b0;
      iA0 = '0; iB0 = '0; iA1 = '0; iB1 = '0;
      core_if.iA_cipher = '0; core_if.iB_cipher = '0;
      core_if.iA_decipher = '0; core_if.iB_decipher = '0;
      core_if.iDoneCipher = 1'b0; core_if.iDoneDecipher = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_key_ready", oKeyReady, 1);
      check_eq("rst_key_loaded", oKeyLoaded, 0);
      check_eq("rst_wen", core_if.oWen, 0);
      check_eq("rst_busy", oBusy, 0);
      check_eq("rst_starts", 32'(core_if.oStartCipher | core_if.oStartDecipher), 0);
      check_eq("rst_resp_valid", oRespValid, 0);
      rst = 1'b1;
      @(negedge clk);

      load_key(8'h00, 8'h00);
      @(negedge clk);
      check_eq("wen_after_load", core_if.oWen, 0);

      iReq0 = 1'b1; iOp0 = 1'b0; iA0 = 32'h0; iB0 = 32'h0;
      do_job(0, 1'b0, 32'h0, 32'h0, 3, 32'hEEDBA521, 32'h6D8F4B15, 1'b1, 1'b0, 1'b0);

      iReq1 = 1'b1; iOp1 = 1'b1; iA1 = 32'hEEDBA521; iB1 = 32'h6D8F4B15;
      do_job(1, 1'b1, 32'hEEDBA521, 32'h6D8F4B15, 4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Both requesters held: grants must alternate, starting with 0 after 1 was served.
      iReq0 = 1'b1; iOp0 = 1'b0; iA0 = 32'h11111111; iB0 = 32'h22222222;
      iReq1 = 1'b1; iOp1 = 1'b1; iA1 = 32'h33333333; iB1 = 32'h44444444;
      for (int k = 0; k < 4; k++) begin
         do_job(k % 2, k[0], (k % 2) ? 32'h33333333 : 32'h11111111,
                (k % 2) ? 32'h44444444 : 32'h22222222, 2, 32'h1000 + k, 32'h2000 + k,
                1'b0, k > 0, 1'b0);
      end
      iReq0 = 1'b0; iReq1 = 1'b0;

      // Reload arrives mid-job: job finishes, then a fresh key is required before the next grant.
      @(negedge clk);
      iReq0 = 1'b1; iOp0 = 1'b0; iA0 = 32'h5; iB0 = 32'h6;
      do_job(0, 1'b0, 32'h5, 32'h6, 3, 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b0, 1'b1);
      iReq0 = 1'b1; iA0 = 32'h7; iB0 = 32'h8;
      @(negedge clk);
      check_eq("reload_key_loaded", oKeyLoaded, 0);
      check_eq("reload_key_ready", oKeyReady, 1);
      check_eq("reload_busy", oBusy, 0);
      load_key(8'hA0, 8'h01);
      do_job(0, 1'b0, 32'h7, 32'h8, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a job.
      iReq1 = 1'b1; iOp1 = 1'b0; iA1 = 32'hFACE0001; iB1 = 32'hFACE0002;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!oGnt1 && waited < 20);
      check_eq("rst_job_gnt", oGnt1, 1);
      iReq1 = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("arst_start", core_if.oStartCipher, 0);
      check_eq("arst_busy", oBusy, 0);
      check_eq("arst_oa", core_if.oA, 0);
      check_eq("arst_loaded", oKeyLoaded, 0);
      @(negedge clk);
      rst = 1'b1;
      iReq0 = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("post_rst_key_ready", oKeyReady, 1);
      check_eq("post_rst_loaded", oKeyLoaded, 0);
      check_eq("post_rst_no_gnt", 32'(oGnt0 | oGnt1), 0);
      check_eq("post_rst_busy", oBusy, 0);
      iReq0 = 1'b0;

`ifdef RC5_SCHED_TIMEOUT_EN
      load_key(8'h00, 8'h00);
      iReq0 = 1'b1; iOp0 = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!oGnt0 && waited < 20);
      check_eq("tmo_gnt", oGnt0, 1);
      iReq0 = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!oRespValid && waited < 5000);
      check_eq("tmo_cycles", waited, 4095);
      check_eq("tmo_flag", oTimeout, 1);
      check_eq("tmo_resp_a", oRespA, 0);
      check_eq("tmo_resp_b", oRespB, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rc5_job_scheduler.md
Name: rc5_job_scheduler

Overview:
- Front-end controller for the RC5 core (dut): streams key bytes into its key RAM, then arbitrates cipher/decipher jobs from two requesters.
- Holds the dut's start level for each granted job until the matching done, then returns the result on a shared response bus.
- Sits between the system bus agents and dut; the only block that drives dut inputs.

Parameters:
W, 32, word width; matches dut W.
B, 16, key length in bytes; key RAM depth.
B_LENGTH, $clog2(B), key address width (derived, not overridden).
TIMEOUT, 4095, max cycles waited for done (used only with RC5_SCHED_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
iKeyValid  in  1  key byte valid
iKeyByte  in  8  key byte, byte 0 first
oKeyReady  out  1  key byte accepted when iKeyValid&&oKeyReady
iKeyReload  in  1  pulse: restart key load
oKeyLoaded  out  1  all B bytes written
iReq0/iReq1  in  1  job request, held until grant
iOp0/iOp1  in  1  0=cipher, 1=decipher
iA0,iB0/iA1,iB1  in  W  job operand words
oGnt0/oGnt1  out  1  one-cycle grant; operands captured
oRespValid  out  1  one-cycle result strobe
oRespId  out  1  requester of result
oRespA/oRespB  out  W  result words
oKey_sub_i  out  8  to dut iKey_sub_i
oKey_address  out  B_LENGTH  to dut iKey_address
oWen  out  1  to dut iWen
oStartCipher/oStartDecipher  out  1  to dut start inputs
oA/oB  out  W  to dut iA/iB and iA_cipher/iB_cipher
iA_cipher,iB_cipher,iA_decipher,iB_decipher  in  W  dut results
iDoneCipher/iDoneDecipher  in  1  dut done flags
oBusy  out  1  job in flight (RUN/RESP/GAP)

Behaviour:
- All outputs registered. Reset: state KEY_LOAD, key count 0, oKeyReady=1, every other output 0, RR pointer=1 (requester 0 wins first tie).
- KEY_LOAD: each accepted byte -> next cycle oWen=1, oKey_address=count, oKey_sub_i=byte; count++. After byte B-1 accepted: oKeyReady=0, oKeyLoaded=1 on the cycle of the final write, go IDLE. iKeyValid low: no write, count held.
- IDLE: iKeyReload -> KEY_LOAD, count 0, oKeyLoaded=0 (reload beats requests in the same cycle). Otherwise, if any iReq: grant one. Single request -> that one. Both -> the one not last served. Next cycle: oGntN=1, operands/op/id latched, oA/oB driven, matching start asserted, state RUN.
- RUN: start held high, oA/oB stable. Only the done matching op counts (cipher: iDoneCipher; decipher: iDoneDecipher). On done: latch matching result pair, drop start, go RESP.
- RESP: oRespValid=1 for exactly 1 cycle with id/A/B; no backpressure. Then GAP.
- GAP: 1 cycle, both starts low, so the dut re-arms. Then IDLE; a pending reload is taken here.
- oStartCipher and oStartDecipher are never high together.
- iKeyReload outside IDLE is latched and serviced on return to IDLE. The current job completes with the old key.
- Requests while oKeyLoaded=0 are not granted. A request dropped before grant is forgotten.
- Grant-to-done latency depends on the dut; the scheduler adds +1 cycle (done->resp) and +2 cycles (resp, gap) before the next grant can issue.
- Reset mid-operation: immediate return to reset values; key must be reloaded even though RAM contents persist.

Optional Feature:
RC5_SCHED_TIMEOUT_EN
- Defined: RUN counts cycles. At TIMEOUT with no matching done: drop start and go RESP with oRespA=oRespB=0 and extra output oTimeout=1 (1 bit, pulsed with oRespValid).
- Undefined: no counter and no oTimeout port; RUN waits indefinitely.

Test Plan:
- Load 16 zero bytes with iKeyValid held -> oWen on 16 consecutive cycles, addresses 0..15; oKeyLoaded=1 on the last write; oKeyReady=0.
- Zero key; iReq0, cipher, A=0, B=0 -> oGnt0; oStartCipher held until iDoneCipher; oRespValid with id 0, A=0xEEDBA521, B=0x6D8F4B15.
- iReq1 decipher with A=0xEEDBA521, B=0x6D8F4B15 -> oStartDecipher only; response id 1, A=0, B=0.
- iReq0 and iReq1 held together for 4 jobs -> grants alternate 0,1,0,1; each grant follows the GAP cycle; starts never overlap.
- iKeyReload pulsed during RUN -> job completes; then KEY_LOAD; requests ignored until 16 new bytes are written.
- rst low during RUN -> all outputs 0 asynchronously, oKeyReady=1 after release; with timeout enabled and done withheld: oTimeout=1 after 4095 cycles.
